// File: rtl/data_memory.sv
// Single-port byte-wide data RAM for the CPU memory stage.
// Writes are synchronous. The read output is registered, and a read in the same cycle as a write to that address returns the new data.
module data_memory #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    // Register-based array so a single reset cycle can clear every word.
    // The declaration initialisers give a zeroed state at power-up.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
    logic [DATA_W-1:0] rdata_p1    = '0;

    // A same-cycle write wins over the stored word.
    function automatic logic [DATA_W-1:0] read_mux(
        input logic              wr_en,
        input logic [DATA_W-1:0] wr_data,
        input logic [DATA_W-1:0] stored
    );
        return wr_en ? wr_data : stored;
    endfunction

    // ---- stage p0 -> p1: array update and read register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata_p1 <= '0;
        end else begin
            if (mem_write) begin
                mem[addr] <= wdata;
            end
            if (mem_read) begin
                rdata_p1 <= read_mux(mem_write, wdata, mem[addr]);
            end
        end
    end

    assign rdata = rdata_p1;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory.
// The stimulus queues the expected rdata for each checked cycle, and a monitor compares rdata one edge later.
module tb_data_memory;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mem_read = 1'b0;
    logic       mem_write = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       chk = 1'b0;

    typedef struct {
        logic [7:0] exp;
        string      name;
    } sb_item_t;

    sb_item_t sb[$];
    int tests = 0;
    int fails = 0;

    data_memory #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata)
    );

    always #5 clk = ~clk;

    // Drive one cycle at the negedge. When do_chk is set, queue the rdata expected after the coming posedge.
    task automatic cyc(input logic r, input logic rd, input logic wr,
                       input logic [7:0] a, input logic [7:0] d,
                       input logic do_chk, input logic [7:0] e, input string nm);
        sb_item_t it;
        @(negedge clk);
        rst = r; mem_read = rd; mem_write = wr; addr = a; wdata = d; chk = do_chk;
        if (do_chk) begin
            it.exp = e;
            it.name = nm;
            sb.push_back(it);
        end
    endtask

    task automatic wr_op(input logic [7:0] a, input logic [7:0] d);
        cyc(1'b0, 1'b0, 1'b1, a, d, 1'b0, 8'h00, "");
    endtask

    task automatic rd_op(input logic [7:0] a, input logic [7:0] e, input string nm);
        cyc(1'b0, 1'b1, 1'b0, a, 8'h00, 1'b1, e, nm);
    endtask

    // Monitor: check one step after each edge for which a check was queued.
    always begin
        logic     pend;
        sb_item_t it;
        @(posedge clk);
        pend = chk;
        #1;
        if (pend) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_underflow: rdata=%h with no queued expectation", rdata);
            end else begin
                it = sb.pop_front();
                if (rdata !== it.exp) begin
                    fails++;
                    $display("FAIL %s: rdata=%h expected=%h", it.name, rdata, it.exp);
                end
            end
        end
    end

    initial begin
        // Power-up state before any reset
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, "powerup_rdata");
        rd_op(8'h37, 8'h00, "powerup_mem");

        cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, "reset_rdata");
        rd_op(8'h00, 8'h00, "post_rst_0x00");
        rd_op(8'h01, 8'h00, "post_rst_0x01");

        wr_op(8'h0A, 8'hAA);
        wr_op(8'h5B, 8'h55);
        rd_op(8'h0A, 8'hAA, "rd_0x0A");
        rd_op(8'h5B, 8'h55, "rd_0x5B");
        wr_op(8'h0A, 8'h33);
        rd_op(8'h0A, 8'h33, "overwrite_0x0A");

        wr_op(8'h00, 8'hA0);
        wr_op(8'hFF, 8'hB1);
        wr_op(8'h10, 8'h00);
        wr_op(8'h11, 8'hFF);
        rd_op(8'h00, 8'hA0, "bound_0x00");
        rd_op(8'hFF, 8'hB1, "bound_0xFF");
        rd_op(8'h10, 8'h00, "pat_0x10");
        rd_op(8'h11, 8'hFF, "pat_0x11");

        wr_op(8'h20, 8'h77);
        cyc(1'b0, 1'b0, 1'b0, 8'h20, 8'h88, 1'b0, 8'h00, "");
        rd_op(8'h20, 8'h77, "wr_disabled");
        cyc(1'b0, 1'b0, 1'b0, 8'h11, 8'h00, 1'b1, 8'h77, "rdata_hold");

        for (int i = 0; i < 16; i++) wr_op(8'h40 + 8'(i), 8'h10 + 8'(i));
        for (int i = 0; i < 16; i++) rd_op(8'h40 + 8'(i), 8'h10 + 8'(i), "stress16");

        for (int i = 0; i < 64; i++) wr_op(8'(i), 8'(i) ^ 8'h5A);
        for (int i = 0; i < 64; i++) rd_op(8'(i), 8'(i) ^ 8'h5A, "stress64");

        for (int i = 0; i < 8; i++) wr_op(8'h80 + 8'(i), 8'hC0 + 8'(i));
        rd_op(8'h87, 8'hC7, "order_0x87");
        rd_op(8'h80, 8'hC0, "order_0x80");
        rd_op(8'h83, 8'hC3, "order_0x83");

        cyc(1'b0, 1'b1, 1'b1, 8'h0A, 8'hFF, 1'b1, 8'hFF, "write_first");
        rd_op(8'h0A, 8'hFF, "write_first_stored");

        // Reset takes priority over a simultaneous read and write
        cyc(1'b1, 1'b1, 1'b1, 8'h5B, 8'h99, 1'b1, 8'h00, "rst_priority");
        rd_op(8'h5B, 8'h00, "rst_clear_0x5B");
        rd_op(8'h0A, 8'h00, "rst_clear_0x0A");
        rd_op(8'hFF, 8'h00, "rst_clear_0xFF");

        cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, "");
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
